// File: rtl/a1k0n_demo.sv
// rtl/a1k0n_demo.sv - 640x480@60 VGA XOR/plasma pattern generator with frame-stepped square-wave tone
module a1k0n_demo (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [9:0] H_LAST       = 10'd799;
  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_FIRST = 10'd656;
  localparam logic [9:0] H_SYNC_LAST  = 10'd751;
  localparam logic [9:0] V_LAST       = 10'd524;
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_FIRST = 10'd490;
  localparam logic [9:0] V_SYNC_LAST  = 10'd491;

  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic [9:0]  frame;
  logic [19:0] acc;
  logic [19:0] step;

  logic        line_end;
  logic        frame_end;
  logic        visible;
  logic        hsync;
  logic        vsync;
  logic [7:0]  u;
  logic [7:0]  w;
  logic [1:0]  red;
  logic [1:0]  green;
  logic [1:0]  blue;
  logic [7:0]  pixel_word;

  // ena, uio_in and the spare ui_in bits have no function here
  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:2]};

  assign uio_oe    = 8'h80;
  assign line_end  = (hcnt == H_LAST);
  assign frame_end = line_end && (vcnt == V_LAST);

  // Tone pitch rises in eight steps across the 1024-frame cycle
  assign step = 20'd20 + {14'd0, frame[9:7], 3'b000};

  // Raster position and frame counters; frame holds while animation is paused
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt  <= '0;
      vcnt  <= '0;
      frame <= '0;
    end else begin
      hcnt <= line_end ? 10'd0 : hcnt + 10'd1;
      if (line_end) begin
        vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
      end
      if (frame_end && !ui_in[0]) begin
        frame <= frame + 10'd1;
      end
    end
  end

  // Pattern and sync decode from the current raster position
  always_comb begin
    visible = (hcnt < H_VISIBLE) && (vcnt < V_VISIBLE);
    hsync   = !((hcnt >= H_SYNC_FIRST) && (hcnt <= H_SYNC_LAST));
    vsync   = !((vcnt >= V_SYNC_FIRST) && (vcnt <= V_SYNC_LAST));
    u       = hcnt[7:0] + frame[7:0];
    w       = vcnt[7:0] + frame[7:0];
    red     = 2'b00;
    green   = 2'b00;
    blue    = 2'b00;
    if (visible) begin
      red   = {u[7], u[6]};
      green = {w[7], w[6]};
      blue  = {u[6] ^ w[6], u[5] ^ w[5]};
    end
    // TinyVGA PMOD pin order: low colour bits on the upper nibble, high bits on the lower
    pixel_word = {hsync, blue[0], green[0], red[0], vsync, blue[1], green[1], red[1]};
  end

  // Register the VGA pins so every output changes exactly one clock after its counters
  always_ff @(posedge clk) begin
    if (rst) begin
      uo_out <= 8'h88;
    end else begin
      uo_out <= pixel_word;
    end
  end

  // Phase accumulator keeps running while muted so unmuting resumes in phase
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      uio_out <= 8'h00;
    end else begin
      acc     <= acc + step;
      uio_out <= {acc[19] & ~ui_in[1], 7'b0000000};
    end
  end

endmodule

// File: tb/tb_a1k0n_demo.sv
// tb/tb_a1k0n_demo.sv - scoreboard bench for a1k0n_demo
module tb_a1k0n_demo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  a1k0n_demo dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #20 clk = ~clk;

  // cyc = number of clock edges since reset was released
  int cyc = 0;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  typedef struct {
    int         at;
    bit         chk_uo;
    logic [7:0] uo;
    bit         chk_uio;
    logic [7:0] uio;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic push(input int at, input bit cu, input logic [7:0] uo,
                      input bit ca, input logic [7:0] uio, input string name);
    exp_t e;
    e.at = at; e.chk_uo = cu; e.uo = uo; e.chk_uio = ca; e.uio = uio; e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    do begin
      @(posedge clk);
      #5;
    end while (cyc < n);
  endtask

  // Monitor: compare DUT outputs when the scoreboard head falls due
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        if (e.at < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s: sample missed, due cycle %0d now %0d", e.name, e.at, cyc);
        end else begin
          if (e.chk_uo) begin
            n_checks++;
            if (uo_out !== e.uo) begin
              n_fail++;
              $display("FAIL %s uo_out: got %h expected %h (cycle %0d)", e.name, uo_out, e.uo, cyc);
            end
          end
          if (e.chk_uio) begin
            n_checks++;
            if (uio_out !== e.uio) begin
              n_fail++;
              $display("FAIL %s uio_out: got %h expected %h (cycle %0d)", e.name, uio_out, e.uio, cyc);
            end
            n_checks++;
            if (uio_oe !== 8'h80) begin
              n_fail++;
              $display("FAIL %s uio_oe: got %h expected 80", e.name, uio_oe);
            end
          end
        end
      end
    end
  end

  // Stimulus: expected values below are hand-derived from the raster/pattern rules
  initial begin
    repeat (3) @(posedge clk);
    #5;
    push(0, 1, 8'h88, 1, 8'h00, "reset_state");
    rst = 1'b0;
    push(1,     1, 8'h88, 1, 8'h00, "pixel_0_0");
    push(225,   1, 8'hDD, 0, 8'h00, "pixel_224_0");
    push(656,   1, 8'h88, 0, 8'h00, "hsync_before");
    push(657,   1, 8'h08, 0, 8'h00, "hsync_fall");
    push(752,   1, 8'h08, 0, 8'h00, "hsync_last_low");
    push(753,   1, 8'h88, 0, 8'h00, "hsync_rise");
    push(1456,  1, 8'h88, 0, 8'h00, "hsync2_before");
    push(1457,  1, 8'h08, 0, 8'h00, "hsync2_fall");
    push(1552,  1, 8'h08, 0, 8'h00, "hsync2_last_low");
    push(1553,  1, 8'h88, 0, 8'h00, "hsync2_rise");
    push(8640,  1, 8'hDC, 0, 8'h00, "pixel_639_10");
    push(8641,  1, 8'h88, 0, 8'h00, "pixel_640_10");
    push(26215, 0, 8'h00, 1, 8'h00, "tone_before_rise");
    push(26216, 0, 8'h00, 1, 8'h80, "tone_first_rise");

    wait_cyc(30000);
    ui_in = 8'h02;
    push(30001, 0, 8'h00, 1, 8'h00, "mute_on");
    push(30500, 0, 8'h00, 1, 8'h00, "mute_held");
    wait_cyc(31000);
    ui_in = 8'h00;
    push(31001, 0, 8'h00, 1, 8'h80, "unmute_in_phase");
    push(40101, 1, 8'h9C, 0, 8'h00, "pixel_100_50");
    push(52429, 0, 8'h00, 1, 8'h80, "tone_last_high");
    push(52430, 0, 8'h00, 1, 8'h00, "tone_fall_wrap");
    push(80201, 1, 8'hF9, 0, 8'h00, "pixel_200_100");
    push(80646, 1, 8'h88, 0, 8'h00, "pixel_645_100");
    push(80701, 1, 8'h08, 0, 8'h00, "pixel_700_100");

    wait_cyc(80701);
    rst = 1'b1;
    @(posedge clk);
    #5;
    push(0, 1, 8'h88, 1, 8'h00, "midframe_reset");
    @(posedge clk);
    #5;
    rst = 1'b0;
    push(1,   1, 8'h88, 1, 8'h00, "post_reset_pixel_0_0");
    push(225, 1, 8'hDD, 1, 8'h00, "post_reset_pixel_224_0");
    push(657, 1, 8'h08, 0, 8'h00, "post_reset_hsync_fall");
    wait_cyc(700);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog bound on total run length
  initial begin
    #4000000;
    $display("FAIL watchdog: run exceeded cycle budget, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
